bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_responder_if.sv | 21 ++
 rtl/bus_responder.sv | 103 ++++++++++
 tb/tb_bus_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_responder_if.sv
// External asynchronous bus control group: chip select, strobes, address and ack.
// The shared data lines are a plain inout on the responder so tristate resolution stays at the top.
interface bus_responder_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  bus_cs_n;
    logic                  bus_rd_n;
    logic                  bus_wr_n;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_ack;

    modport master (
        output bus_cs_n, bus_rd_n, bus_wr_n, bus_addr,
        input  bus_ack
    );

    modport slave (
        input  bus_cs_n, bus_rd_n, bus_wr_n, bus_addr,
        output bus_ack
    );
endinterface

// File: rtl/bus_responder.sv
// Bridges an asynchronous strobe-based external bus to one-cycle internal register
// read/write requests, with one internal access per external strobe assertion.
module bus_responder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_responder_if.slave        bus,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_rd,
    output logic                  reg_wr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_CAP  = 3'd2;
    localparam logic [2:0] RD_HOLD = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;
    localparam logic [2:0] WR_HOLD = 3'd5;

    logic [1:0]            cs_sync, rd_sync, wr_sync;
    logic                  cs_s, rd_s, wr_s;
    logic [1:0]            vld_pipe;
    logic                  armed;
    logic [2:0]            state, state_nxt;
    logic [DATA_WIDTH-1:0] rd_hold;
    logic                  start_rd, start_wr;
    logic                  rd_drive;

    // Synchronizers idle at the strobe-inactive level.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync  <= 2'b11;
            rd_sync  <= 2'b11;
            wr_sync  <= 2'b11;
            vld_pipe <= 2'b00;
        end else begin
            cs_sync  <= {cs_sync[0], bus.bus_cs_n};
            rd_sync  <= {rd_sync[0], bus.bus_rd_n};
            wr_sync  <= {wr_sync[0], bus.bus_wr_n};
            vld_pipe <= {vld_pipe[0], 1'b1};
        end
    end

    assign cs_s = cs_sync[1];
    assign rd_s = rd_sync[1];
    assign wr_s = wr_sync[1];

    assign start_rd = armed && !cs_s && !rd_s &&  wr_s;
    assign start_wr = armed && !cs_s && !wr_s &&  rd_s;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_rd)      state_nxt = RD_REQ;
                else if (start_wr) state_nxt = WR_REQ;
            end
            RD_REQ:  state_nxt = RD_CAP;
            RD_CAP:  state_nxt = RD_HOLD;
            RD_HOLD: if (rd_s || cs_s) state_nxt = IDLE;
            WR_REQ:  state_nxt = WR_HOLD;
            WR_HOLD: if (wr_s || cs_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Right after reset the sync flops still hold their reset 1s, not sampled
    // pins; arming waits until the pipe has refilled so a strobe held low
    // across reset cannot look like a fresh idle bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            rd_hold   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (start_rd || start_wr))
                armed <= 1'b0;
            else if (vld_pipe[1] && cs_s && rd_s && wr_s)
                armed <= 1'b1;
            if (state == IDLE && (start_rd || start_wr))
                reg_addr <= bus.bus_addr;
            if (state == IDLE && start_wr)
                reg_wdata <= bus_data;
            if (state == RD_CAP)
                rd_hold <= reg_rdata;
        end
    end

    assign reg_rd      = (state == RD_REQ);
    assign reg_wr      = (state == WR_REQ);
    assign bus.bus_ack = (state == RD_HOLD) || (state == WR_HOLD);

    // Release follows the raw strobes so the bus frees without waiting for the synchronizer.
    assign rd_drive = (state == RD_HOLD) && !bus.bus_cs_n && !bus.bus_rd_n;
    assign bus_data = rd_drive ? rd_hold : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: expected accesses are queued at stimulus time
// and popped by a monitor on every reg_rd/reg_wr pulse; scenarios check timing inline.
module tb_bus_responder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    wire  [7:0] bus_data;
    logic [7:0] tb_data = 8'h00;
    logic       tb_drive = 1'b0;
    logic [3:0] reg_addr;
    logic       reg_rd, reg_wr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_wr;
        logic [3:0] addr;
        logic [7:0] data;
    } acc_t;
    acc_t sb_q[$];

    bus_responder_if #(.ADDR_WIDTH(4)) bif ();

    bus_responder #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bif),
        .bus_data (bus_data),
        .reg_addr (reg_addr),
        .reg_rd   (reg_rd),
        .reg_wr   (reg_wr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata)
    );

    // Released bus reads back as all ones.
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (bus_data[i]);
    end
    assign bus_data = tb_drive ? tb_data : 8'hzz;

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_val(input logic [3:0] a);
        return 8'h3C ^ {4'h0, a ^ 4'h9};
    endfunction

    // Register file model: data valid the cycle after reg_rd.
    always @(posedge clk) if (reg_rd) reg_rdata <= rd_val(reg_addr);

    always @(negedge clk) begin
        if (reg_rd || reg_wr) begin
            acc_t e;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: rd=%0b wr=%0b addr=%h, required no access", reg_rd, reg_wr, reg_addr);
            end else begin
                e = sb_q.pop_front();
                if (e.is_wr !== reg_wr || e.addr !== reg_addr || (reg_wr && e.data !== reg_wdata)) begin
                    bad++;
                    $display("FAIL sb_access: wr=%0b addr=%h wdata=%h, required wr=%0b addr=%h data=%h",
                             reg_wr, reg_addr, reg_wdata, e.is_wr, e.addr, e.data);
                end
            end
        end
    end

    // mode 0 = read, 1 = write, 2 = both strobes low. Strobes drop at negedge 0 and rise at negedge len.
    task automatic do_xfer(input int mode, input logic [3:0] a, input logic [7:0] d,
                           input int len, input int win,
                           output int first_req, output int req_cnt,
                           output int first_ack, output int ack_cnt,
                           output logic [7:0] data_hold, output logic [7:0] data_rel);
        acc_t e;
        first_req = -1; req_cnt = 0; first_ack = -1; ack_cnt = 0;
        data_hold = 8'h00; data_rel = 8'h00;
        @(negedge clk);
        bif.bus_addr = a;
        tb_data      = d;
        tb_drive     = (mode == 1);
        bif.bus_cs_n = 1'b0;
        bif.bus_rd_n = (mode == 1);
        bif.bus_wr_n = (mode == 0);
        if (mode != 2) begin
            e.is_wr = (mode == 1); e.addr = a; e.data = (mode == 1) ? d : rd_val(a);
            sb_q.push_back(e);
        end
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            if (reg_rd || reg_wr) begin req_cnt++; if (first_req < 0) first_req = k; end
            if (bif.bus_ack) begin ack_cnt++; if (first_ack < 0) first_ack = k; end
            if (k == len) begin
                data_hold = bus_data;
                bif.bus_cs_n = 1'b1; bif.bus_rd_n = 1'b1; bif.bus_wr_n = 1'b1;
                #1 data_rel = bus_data;
            end
        end
        tb_drive = 1'b0;
    endtask

    task automatic test_reset();
        bif.bus_cs_n = 1'b1; bif.bus_rd_n = 1'b1; bif.bus_wr_n = 1'b1; bif.bus_addr = 4'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bif.bus_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", bif.bus_ack); end
        total++; if ({reg_rd, reg_wr} !== 2'b00) begin bad++; $display("FAIL rst_req: got %b want 00", {reg_rd, reg_wr}); end
        total++; if (reg_addr !== 4'h0 || reg_wdata !== 8'h00) begin bad++; $display("FAIL rst_regs: addr=%h wdata=%h want 0/00", reg_addr, reg_wdata); end
        total++; if (bus_data !== 8'hFF) begin bad++; $display("FAIL rst_bus: got %h want released (ff)", bus_data); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        int fr, rc, fa, ac; logic [7:0] dh, dr;
        do_xfer(1, 4'h5, 8'hA3, 8, 14, fr, rc, fa, ac, dh, dr);
        total++; if (rc !== 1) begin bad++; $display("FAIL wr_count: got %0d want 1", rc); end
        total++; if (fr !== 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", fr); end
        total++; if (fa !== 4 || ac !== 7) begin bad++; $display("FAIL wr_ack: first=%0d len=%0d want 4/7", fa, ac); end
        total++; if (reg_addr !== 4'h5 || reg_wdata !== 8'hA3) begin bad++; $display("FAIL wr_regs: addr=%h data=%h want 5/a3", reg_addr, reg_wdata); end
    endtask

    task automatic test_read();
        int fr, rc, fa, ac; logic [7:0] dh, dr;
        do_xfer(0, 4'h9, 8'h00, 10, 16, fr, rc, fa, ac, dh, dr);
        total++; if (rc !== 1) begin bad++; $display("FAIL rd_count: got %0d want 1", rc); end
        total++; if (fr !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", fr); end
        total++; if (fa !== 5 || ac !== 8) begin bad++; $display("FAIL rd_ack: first=%0d len=%0d want 5/8", fa, ac); end
        total++; if (dh !== 8'h3C) begin bad++; $display("FAIL rd_data: got %h want 3c", dh); end
        total++; if (dr !== 8'hFF) begin bad++; $display("FAIL rd_release: got %h want released (ff)", dr); end
    endtask

    task automatic test_both_low();
        int fr, rc, fa, ac; logic [7:0] dh, dr;
        do_xfer(2, 4'h4, 8'h00, 10, 14, fr, rc, fa, ac, dh, dr);
        total++; if (rc !== 0) begin bad++; $display("FAIL both_req: got %0d want 0", rc); end
        total++; if (ac !== 0) begin bad++; $display("FAIL both_ack: got %0d want 0", ac); end
        total++; if (dh !== 8'hFF) begin bad++; $display("FAIL both_bus: got %h want released (ff)", dh); end
    endtask

    task automatic test_reset_mid();
        acc_t e;
        int wr_cnt, ack_cnt, fr, rc, fa, ac; logic [7:0] dh, dr;
        @(negedge clk);
        bif.bus_addr = 4'h7; tb_data = 8'h11; tb_drive = 1'b1;
        bif.bus_cs_n = 1'b0; bif.bus_wr_n = 1'b0;
        e.is_wr = 1'b1; e.addr = 4'h7; e.data = 8'h11; sb_q.push_back(e);
        repeat (5) @(negedge clk);
        total++; if (bif.bus_ack !== 1'b1) begin bad++; $display("FAIL mid_hold_ack: got %b want 1", bif.bus_ack); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (bif.bus_ack !== 1'b0) begin bad++; $display("FAIL mid_ack_cleared: got %b want 0", bif.bus_ack); end
        total++; if (reg_addr !== 4'h0 || reg_wdata !== 8'h00) begin bad++; $display("FAIL mid_regs: addr=%h data=%h want 0/00", reg_addr, reg_wdata); end
        wr_cnt = 0; ack_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (reg_wr) wr_cnt++;
            if (bif.bus_ack) ack_cnt++;
        end
        total++; if (wr_cnt !== 0 || ack_cnt !== 0) begin bad++; $display("FAIL mid_no_rewrite: wr=%0d ack=%0d want 0/0", wr_cnt, ack_cnt); end
        bif.bus_cs_n = 1'b1; bif.bus_wr_n = 1'b1; tb_drive = 1'b0;
        repeat (4) @(negedge clk);
        do_xfer(1, 4'h7, 8'h22, 3, 9, fr, rc, fa, ac, dh, dr);
        total++; if (rc !== 1 || fr !== 3) begin bad++; $display("FAIL mid_new_write: count=%0d at=%0d want 1/3", rc, fr); end
    endtask

    task automatic test_short_write();
        int fr, rc, fa, ac; logic [7:0] dh, dr;
        do_xfer(1, 4'h3, 8'hC5, 1, 8, fr, rc, fa, ac, dh, dr);
        total++; if (rc !== 1 || fr !== 3) begin bad++; $display("FAIL short_req: count=%0d at=%0d want 1/3", rc, fr); end
        total++; if (ac !== 1 || fa !== 4) begin bad++; $display("FAIL short_ack: len=%0d at=%0d want 1/4", ac, fa); end
    endtask

    task automatic test_back_to_back();
        int fr, rc, fa, ac; logic [7:0] dh, dr;
        do_xfer(0, 4'h2, 8'h00, 6, 10, fr, rc, fa, ac, dh, dr);
        total++; if (rc !== 1 || fa !== 5 || ac !== 4) begin bad++; $display("FAIL b2b_read: count=%0d ack_at=%0d ack_len=%0d want 1/5/4", rc, fa, ac); end
        total++; if (dh !== rd_val(4'h2)) begin bad++; $display("FAIL b2b_rdata: got %h want %h", dh, rd_val(4'h2)); end
        do_xfer(1, 4'hE, 8'h5A, 3, 9, fr, rc, fa, ac, dh, dr);
        total++; if (rc !== 1 || fa !== 4 || ac !== 2) begin bad++; $display("FAIL b2b_write: count=%0d ack_at=%0d ack_len=%0d want 1/4/2", rc, fa, ac); end
        total++; if (reg_addr !== 4'hE || reg_wdata !== 8'h5A) begin bad++; $display("FAIL b2b_regs: addr=%h data=%h want e/5a", reg_addr, reg_wdata); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_both_low();
        test_reset_mid();
        test_short_write();
        test_back_to_back();
        repeat (3) @(negedge clk);
        total++; if (sb_q.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
